// File: rtl/cp0_unit_pkg.sv
// -----------------------------------------------------------------------------
// cp0_unit_pkg
// Shared constants for the CP0 block and its timer:
//   - CP0 register numbers used by MFC0/MTC0 decoding
//   - ExcCode values that also capture BadVAddr (AdEL/AdES)
//   - Status/Cause bit positions
//   - encoding of the exception-level state (Status.EXL)
// -----------------------------------------------------------------------------
package cp0_unit_pkg;

   // CP0 register numbers
   localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
   localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
   localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_REG_EPC      = 5'd14;
   localparam logic [4:0] CP0_REG_PRID     = 5'd15;

   // Address-error exception codes
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   // Status bit positions
   localparam int STATUS_IE_BIT  = 0;
   localparam int STATUS_EXL_BIT = 1;
   localparam int STATUS_IM_LSB  = 8;
   localparam int STATUS_BEV_BIT = 22;

   // Cause bit positions
   localparam int CAUSE_EXC_LSB = 2;
   localparam int CAUSE_IP_LSB  = 8;
   localparam int CAUSE_TI_BIT  = 30;
   localparam int CAUSE_BD_BIT  = 31;

   // Exception level: the core is either running normally or inside a handler.
   typedef enum logic {
      EXL_CLEAR = 1'b0,
      EXL_SET   = 1'b1
   } exl_state_e;

   // Address-error exceptions are the only ones that latch BadVAddr.
   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
// Count/Compare timer of CP0. A prescaler counts 0..COUNT_DIV-1 and Count
// increments on its wrap. TI is a sticky flag set when Count takes a value
// equal to Compare and cleared by a Compare write.
// Ports:
//   clk           clock
//   rst           asynchronous active-low reset
//   count_we_i    MTC0 to Count this cycle (loads, restarts prescaler)
//   compare_we_i  MTC0 to Compare this cycle (loads, clears TI)
//   wdata_i       MTC0 data
//   count_o       current Count
//   compare_o     current Compare
//   ti_o          timer interrupt flag (Cause.TI)
// -----------------------------------------------------------------------------
module cp0_timer
   import cp0_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int COUNT_DIV  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  count_we_i,
   input  logic                  compare_we_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] count_o,
   output logic [DATA_WIDTH-1:0] compare_o,
   output logic                  ti_o
);

   // A divide-by-1 still needs a one-bit prescaler that is permanently at its wrap value.
   localparam int              DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

   logic [DIV_W-1:0]      div_q, div_d;
   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic [DATA_WIDTH-1:0] compare_q, compare_d;
   logic                  ti_q, ti_d;
   logic                  count_upd;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      div_d     = div_q;
      count_d   = count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      count_upd = 1'b0;

      // A Count write replaces that cycle's increment and restarts the prescaler.
      if (count_we_i) begin
         count_d   = wdata_i;
         div_d     = '0;
         count_upd = 1'b1;
      end else if (div_q == DIV_LAST) begin
         count_d   = count_q + DATA_WIDTH'(1);
         div_d     = '0;
         count_upd = 1'b1;
      end else begin
         div_d = div_q + DIV_W'(1);
      end

      // Match is evaluated only when Count takes a new value, so a freshly
      // reset timer (Count = Compare = 0) does not raise TI spuriously.
      // A Compare write acknowledges the interrupt and wins over a match.
      if (compare_we_i) begin
         compare_d = wdata_i;
         ti_d      = 1'b0;
      end else if (count_upd && (count_d == compare_q)) begin
         ti_d = 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q     <= '0;
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         div_q     <= div_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// -----------------------------------------------------------------------------
// cp0_unit
// MIPS32-subset coprocessor 0: Count/Compare timer, Status, Cause, EPC,
// BadVAddr and PRId. Captures exception/ERET events from the commit stage,
// serves MFC0 reads with one cycle of latency and raises int_req.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   read_addr         MFC0 register number
//   data_out          registered MFC0 read data
//   write_en          MTC0 strobe
//   write_addr        MTC0 register number
//   write_data        MTC0 data
//   interrupt         level hardware interrupt lines (-> Cause.IP[2+:NUM_HW_INT])
//   exc_valid         exception committed this cycle
//   exc_code          Cause.ExcCode value
//   exc_pc            PC of the faulting instruction
//   exc_delay_slot    faulting instruction sits in a branch delay slot
//   exc_bad_vaddr     faulting address for AdEL/AdES
//   eret              ERET committed this cycle
//   status_out        current Status
//   cause_out         current Cause
//   epc_out           current EPC (ERET target)
//   int_req           registered interrupt request to the pipeline
// -----------------------------------------------------------------------------
module cp0_unit
   import cp0_unit_pkg::*;
#(
   parameter int                  DATA_WIDTH = 32,
   parameter int                  NUM_HW_INT = 6,
   parameter int                  COUNT_DIV  = 2,
   parameter logic [DATA_WIDTH-1:0] PRID_VALUE = 32'h0000_4220
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4:0]            read_addr,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  write_en,
   input  logic [4:0]            write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [NUM_HW_INT-1:0] interrupt,
   input  logic                  exc_valid,
   input  logic [4:0]            exc_code,
   input  logic [DATA_WIDTH-1:0] exc_pc,
   input  logic                  exc_delay_slot,
   input  logic [DATA_WIDTH-1:0] exc_bad_vaddr,
   input  logic                  eret,
   output logic [DATA_WIDTH-1:0] status_out,
   output logic [DATA_WIDTH-1:0] cause_out,
   output logic [DATA_WIDTH-1:0] epc_out,
   output logic                  int_req
);

   // Architectural state
   exl_state_e            state_q, state_d;       // Status.EXL
   logic [7:0]            im_q, im_d;             // Status.IM
   logic                  ie_q, ie_d;             // Status.IE
   logic [1:0]            ip_sw_q, ip_sw_d;       // Cause.IP[1:0], software interrupts
   logic [5:0]            hw_ip_q, hw_ip_d;       // Cause.IP[7:2] before the TI merge
   logic [4:0]            exc_code_q, exc_code_d; // Cause.ExcCode
   logic                  bd_q, bd_d;             // Cause.BD
   logic [DATA_WIDTH-1:0] epc_q, epc_d;
   logic [DATA_WIDTH-1:0] badvaddr_q, badvaddr_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  int_req_q, int_req_d;

   // Timer interface
   logic                  count_we, compare_we;
   logic [DATA_WIDTH-1:0] count_val, compare_val;
   logic                  ti;

   // Assembled register views
   logic [DATA_WIDTH-1:0] status_val, cause_val;
   logic [7:0]            ip_all;

   assign count_we   = write_en && (write_addr == CP0_REG_COUNT);
   assign compare_we = write_en && (write_addr == CP0_REG_COMPARE);

   // The timer runs every cycle regardless of exceptions; only its own MTC0 writes steer it.
   cp0_timer #(
      .DATA_WIDTH (DATA_WIDTH),
      .COUNT_DIV  (COUNT_DIV)
   ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .count_we_i   (count_we),
      .compare_we_i (compare_we),
      .wdata_i      (write_data),
      .count_o      (count_val),
      .compare_o    (compare_val),
      .ti_o         (ti)
   );

   // Register views: unlisted Status/Cause bits are constant zero, BEV stays at its reset value of 1.
   always_comb begin
      status_val                          = '0;
      status_val[STATUS_BEV_BIT]          = 1'b1;
      status_val[STATUS_IM_LSB +: 8]      = im_q;
      status_val[STATUS_EXL_BIT]          = (state_q == EXL_SET);
      status_val[STATUS_IE_BIT]           = ie_q;

      // IP7 doubles as the timer interrupt line.
      ip_all                              = {hw_ip_q[5] | ti, hw_ip_q[4:0], ip_sw_q};

      cause_val                           = '0;
      cause_val[CAUSE_BD_BIT]             = bd_q;
      cause_val[CAUSE_TI_BIT]             = ti;
      cause_val[CAUSE_IP_LSB +: 8]        = ip_all;
      cause_val[CAUSE_EXC_LSB +: 5]       = exc_code_q;
   end

   // Next-state logic. Sources are applied lowest priority first
   // (MTC0, then ERET, then exception) so the stronger event overrides
   // only the fields it owns; every other MTC0 field still commits.
   always_comb begin
      state_d    = state_q;
      im_d       = im_q;
      ie_d       = ie_q;
      ip_sw_d    = ip_sw_q;
      exc_code_d = exc_code_q;
      bd_d       = bd_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;

      // Unused lines above NUM_HW_INT are zero-extended away.
      hw_ip_d    = 6'(interrupt);

      if (write_en) begin
         case (write_addr)
            CP0_REG_STATUS: begin
               im_d    = write_data[STATUS_IM_LSB +: 8];
               ie_d    = write_data[STATUS_IE_BIT];
               state_d = write_data[STATUS_EXL_BIT] ? EXL_SET : EXL_CLEAR;
            end
            CP0_REG_CAUSE: ip_sw_d = write_data[CAUSE_IP_LSB +: 2];
            CP0_REG_EPC:   epc_d   = write_data;
            default: ;
         endcase
      end

      if (eret) begin
         state_d = EXL_CLEAR;
      end

      if (exc_valid) begin
         state_d    = EXL_SET;
         exc_code_d = exc_code;
         // A nested exception keeps the original return point and BD.
         if (state_q == EXL_CLEAR) begin
            epc_d = exc_delay_slot ? (exc_pc - DATA_WIDTH'(4)) : exc_pc;
            bd_d  = exc_delay_slot;
         end
         if (is_addr_exc(exc_code)) begin
            badvaddr_d = exc_bad_vaddr;
         end
      end

      int_req_d = ie_q && (state_q == EXL_CLEAR) && |(ip_all & im_q);

      // Reads see pre-edge contents; a same-cycle MTC0 is not forwarded because the pipeline interlocks.
      case (read_addr)
         CP0_REG_BADVADDR: rdata_d = badvaddr_q;
         CP0_REG_COUNT:    rdata_d = count_val;
         CP0_REG_COMPARE:  rdata_d = compare_val;
         CP0_REG_STATUS:   rdata_d = status_val;
         CP0_REG_CAUSE:    rdata_d = cause_val;
         CP0_REG_EPC:      rdata_d = epc_q;
         CP0_REG_PRID:     rdata_d = PRID_VALUE;
         default:          rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= EXL_CLEAR;
         im_q       <= '0;
         ie_q       <= 1'b0;
         ip_sw_q    <= '0;
         hw_ip_q    <= '0;
         exc_code_q <= '0;
         bd_q       <= 1'b0;
         epc_q      <= '0;
         badvaddr_q <= '0;
         rdata_q    <= '0;
         int_req_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         im_q       <= im_d;
         ie_q       <= ie_d;
         ip_sw_q    <= ip_sw_d;
         hw_ip_q    <= hw_ip_d;
         exc_code_q <= exc_code_d;
         bd_q       <= bd_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
         rdata_q    <= rdata_d;
         int_req_q  <= int_req_d;
      end
   end

   assign data_out   = rdata_q;
   assign status_out = status_val;
   assign cause_out  = cause_val;
   assign epc_out    = epc_q;
   assign int_req    = int_req_q;

endmodule

// File: tb/tb_cp0_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_unit
// Directed sequence for reset, timer, exceptions, ERET and interrupts,
// followed by a randomized run of exceptions/ERETs/MTC0 writes checked
// against a behavioural model of the architectural registers.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_cp0_unit;

   localparam int TB_DIV = 2;

   logic        clk;
   logic        rst;
   logic [4:0]  read_addr;
   logic [31:0] data_out;
   logic        write_en;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [5:0]  interrupt;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_delay_slot;
   logic [31:0] exc_bad_vaddr;
   logic        eret;
   logic [31:0] status_out;
   logic [31:0] cause_out;
   logic [31:0] epc_out;
   logic        int_req;

   cp0_unit #(
      .DATA_WIDTH (32),
      .NUM_HW_INT (6),
      .COUNT_DIV  (TB_DIV),
      .PRID_VALUE (32'h0000_4220)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .read_addr      (read_addr),
      .data_out       (data_out),
      .write_en       (write_en),
      .write_addr     (write_addr),
      .write_data     (write_data),
      .interrupt      (interrupt),
      .exc_valid      (exc_valid),
      .exc_code       (exc_code),
      .exc_pc         (exc_pc),
      .exc_delay_slot (exc_delay_slot),
      .exc_bad_vaddr  (exc_bad_vaddr),
      .eret           (eret),
      .status_out     (status_out),
      .cause_out      (cause_out),
      .epc_out        (epc_out),
      .int_req        (int_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      write_en   = 1'b1;
      write_addr = a;
      write_data = d;
      tick();
      write_en   = 1'b0;
   endtask

   task automatic mfc0(input logic [4:0] a, output logic [31:0] d);
      read_addr = a;
      tick();
      d = data_out;
   endtask

   task automatic take_exc(input logic [4:0] code, input logic [31:0] pc, input logic slot,
                           input logic [31:0] va, input logic with_eret);
      exc_valid      = 1'b1;
      exc_code       = code;
      exc_pc         = pc;
      exc_delay_slot = slot;
      exc_bad_vaddr  = va;
      eret           = with_eret;
      tick();
      exc_valid      = 1'b0;
      eret           = 1'b0;
   endtask

   // Count after a write of v followed by r clock edges.
   function automatic logic [31:0] exp_count(input logic [31:0] v, input int r);
      return v + 32'(r / TB_DIV);
   endfunction

   // Behavioural model of the exception-related architectural state.
   logic        m_exl, m_ie, m_bd;
   logic [7:0]  m_im;
   logic [1:0]  m_ipsw;
   logic [4:0]  m_code;
   logic [31:0] m_epc, m_badv;

   function automatic logic [31:0] m_status();
      return 32'h0040_0000 | {16'h0, m_im, 6'h0, m_exl, m_ie};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;

      rst = 1'b0;
      read_addr = 5'd9;
      write_en = 1'b0; write_addr = '0; write_data = '0;
      interrupt = '0;
      exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_delay_slot = 1'b0; exc_bad_vaddr = '0;
      eret = 1'b0;
      #1;
      check("reset_status", status_out, 32'h0040_0000);
      check("reset_cause", cause_out, 32'h0);
      check("reset_epc", epc_out, 32'h0);
      check("reset_int_req", {31'h0, int_req}, 32'h0);
      check("reset_data_out", data_out, 32'h0);
      #20 rst = 1'b1;
      tick();
      check("mfc0_count_after_reset", data_out, 32'h0);
      mfc0(5'd12, rd);
      check("mfc0_status_after_reset", rd, 32'h0040_0000);
      mfc0(5'd15, rd);
      check("mfc0_prid", rd, 32'h0000_4220);
      mfc0(5'd3, rd);
      check("mfc0_unmapped", rd, 32'h0);

      // Timer: Compare=5, Count=0 -> TI on the 10th edge after the Count write.
      mtc0(5'd12, 32'h0000_8001);
      check("status_im7_ie", status_out, 32'h0040_8001);
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      repeat (9) tick();
      check("ti_before_match", {31'h0, cause_out[30]}, 32'h0);
      tick();
      check("ti_at_match", {31'h0, cause_out[30]}, 32'h1);
      check("ip7_from_ti", {31'h0, cause_out[15]}, 32'h1);
      check("int_req_lag", {31'h0, int_req}, 32'h0);
      tick();
      check("int_req_timer", {31'h0, int_req}, 32'h1);
      mfc0(5'd11, rd);
      check("mfc0_compare", rd, 32'd5);
      mtc0(5'd11, 32'h1000_0000);
      check("ti_cleared", {31'h0, cause_out[30]}, 32'h0);
      tick();
      check("int_req_after_clear", {31'h0, int_req}, 32'h0);

      // Count loads and advances at 1/TB_DIV; includes the 32-bit wrap.
      for (int i = 0; i < 6; i++) begin
         logic [31:0] v;
         int r;
         v = (i == 4 || i == 5) ? 32'hFFFF_FFFF : $urandom;
         r = (i == 4) ? 2 : (i == 5) ? 1 : int'($urandom_range(0, 9));
         mtc0(5'd9, v);
         repeat (r) tick();
         mfc0(5'd9, rd);
         check($sformatf("count_%0d", i), rd, exp_count(v, r));
      end

      // Address error in a delay slot.
      take_exc(5'd4, 32'hBFC0_0100, 1'b1, 32'h0000_0001, 1'b0);
      check("exc1_epc", epc_out, 32'hBFC0_00FC);
      check("exc1_bd", {31'h0, cause_out[31]}, 32'h1);
      check("exc1_code", {27'h0, cause_out[6:2]}, 32'd4);
      check("exc1_status", status_out, 32'h0040_8003);
      mfc0(5'd8, rd);
      check("exc1_badvaddr", rd, 32'h0000_0001);
      mfc0(5'd14, rd);
      check("exc1_mfc0_epc", rd, 32'hBFC0_00FC);

      // Nested exception: EPC/BD kept, BadVAddr untouched for a non-address code.
      take_exc(5'd12, 32'h8000_1000, 1'b0, 32'h0000_DEAD, 1'b0);
      check("exc2_epc", epc_out, 32'hBFC0_00FC);
      check("exc2_bd", {31'h0, cause_out[31]}, 32'h1);
      check("exc2_code", {27'h0, cause_out[6:2]}, 32'd12);
      mfc0(5'd8, rd);
      check("exc2_badvaddr", rd, 32'h0000_0001);

      eret = 1'b1; tick(); eret = 1'b0;
      check("eret_clears_exl", status_out, 32'h0040_8001);

      // Exception + ERET + Compare write in one cycle.
      write_en = 1'b1; write_addr = 5'd11; write_data = 32'h2000_0000;
      take_exc(5'd0, 32'h8000_0200, 1'b0, 32'h0, 1'b1);
      write_en = 1'b0;
      check("exc_eret_exl", status_out, 32'h0040_8003);
      check("exc_eret_epc", epc_out, 32'h8000_0200);
      check("exc_eret_bd", {31'h0, cause_out[31]}, 32'h0);
      mfc0(5'd11, rd);
      check("exc_with_compare_write", rd, 32'h2000_0000);
      eret = 1'b1; tick(); eret = 1'b0;
      check("eret2_status", status_out, 32'h0040_8001);

      // Hardware interrupt line 0 -> IP2.
      interrupt = 6'b000001;
      mtc0(5'd12, 32'h0000_0401);
      check("hw_ip2", {31'h0, cause_out[10]}, 32'h1);
      tick();
      check("int_req_hw", {31'h0, int_req}, 32'h1);
      mtc0(5'd12, 32'h0000_0403);
      tick();
      check("int_req_masked_by_exl", {31'h0, int_req}, 32'h0);
      mtc0(5'd12, 32'h0000_0401);
      tick();
      check("int_req_restored", {31'h0, int_req}, 32'h1);

      // Randomized exceptions/ERETs/MTC0 against the model.
      m_exl = 1'b0; m_ie = 1'b1; m_im = 8'h04; m_bd = 1'b0; m_ipsw = 2'b00;
      m_code = 5'd0; m_epc = 32'h8000_0200; m_badv = 32'h0000_0001;
      for (int i = 0; i < 40; i++) begin
         logic [31:0] d, pc, va, exp_cause;
         logic [4:0]  code;
         logic        slot, do_exc, do_eret, old_exl;
         logic [5:0]  irq;
         int          wsel;
         d       = $urandom;
         pc      = $urandom & 32'hFFFF_FFFC;
         va      = $urandom;
         code    = ($urandom_range(0, 2) == 0) ? 5'(4 + $urandom_range(0, 1)) : 5'($urandom_range(0, 31));
         slot    = 1'($urandom_range(0, 1));
         do_exc  = ($urandom_range(0, 3) == 0);
         do_eret = ($urandom_range(0, 3) == 0);
         irq     = 6'($urandom);
         wsel    = int'($urandom_range(0, 3));

         write_en   = (wsel != 0);
         write_addr = (wsel == 1) ? 5'd12 : (wsel == 2) ? 5'd14 : 5'd13;
         write_data = d;
         interrupt  = irq;
         exc_valid = do_exc; exc_code = code; exc_pc = pc; exc_delay_slot = slot; exc_bad_vaddr = va;
         eret = do_eret;
         tick();
         write_en = 1'b0; exc_valid = 1'b0; eret = 1'b0;

         old_exl = m_exl;
         if (wsel == 1) begin m_ie = d[0]; m_exl = d[1]; m_im = d[15:8]; end
         if (wsel == 2) m_epc = d;
         if (wsel == 3) m_ipsw = d[9:8];
         if (do_eret) m_exl = 1'b0;
         if (do_exc) begin
            m_exl  = 1'b1;
            m_code = code;
            if (!old_exl) begin
               m_epc = slot ? pc - 32'd4 : pc;
               m_bd  = slot;
            end
            if (code == 5'd4 || code == 5'd5) m_badv = va;
         end

         exp_cause = {m_bd, 16'h0, irq[4:0], m_ipsw, 1'b0, m_code, 2'b00};
         check($sformatf("rnd%0d_status", i), status_out, m_status());
         check($sformatf("rnd%0d_epc", i), epc_out, m_epc);
         check($sformatf("rnd%0d_cause", i), cause_out & 32'h8000_7F7C, exp_cause);
      end
      mfc0(5'd8, rd);
      check("rnd_badvaddr", rd, m_badv);

      // Asynchronous reset in the middle of a cycle.
      interrupt = 6'b000001;
      mtc0(5'd12, 32'h0000_0401);
      tick();
      check("pre_reset_int_req", {31'h0, int_req}, 32'h1);
      mfc0(5'd12, rd);
      check("pre_reset_data_out", rd, 32'h0040_0401);
      #3 rst = 1'b0;
      #1;
      check("midreset_status", status_out, 32'h0040_0000);
      check("midreset_cause", cause_out, 32'h0);
      check("midreset_epc", epc_out, 32'h0);
      check("midreset_int_req", {31'h0, int_req}, 32'h0);
      check("midreset_data_out", data_out, 32'h0);
      interrupt = '0;
      read_addr = 5'd9;
      #2 rst = 1'b1;
      tick();
      check("post_reset_count", data_out, 32'h0);
      mfc0(5'd11, rd);
      check("post_reset_compare", rd, 32'h0);
      mfc0(5'd8, rd);
      check("post_reset_badvaddr", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
